// File: rtl/spectrum_bar_renderer.sv
// VGA spectrum-analyser renderer: sync timing, NUM_BANDS gradient bars and
// per-band decaying peak markers, all outputs registered one cycle after (h,v).
module spectrum_bar_renderer #(
  parameter int H_DISPLAY         = 640,
  parameter int H_FRONT           = 16,
  parameter int H_SYNC            = 96,
  parameter int H_BACK            = 48,
  parameter int V_DISPLAY         = 480,
  parameter int V_FRONT           = 10,
  parameter int V_SYNC            = 2,
  parameter int V_BACK            = 33,
  parameter int NUM_BANDS         = 16,
  parameter int BAR_WIDTH         = 40,
  parameter int GAP               = 2,
  parameter int MAG_W             = 16,
  parameter int PEAK_DECAY_FRAMES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       done,
  input  logic [NUM_BANDS*MAG_W-1:0] bands,
  output logic                       hsync,
  output logic                       vsync,
  output logic [3:0]                 r,
  output logic [3:0]                 g,
  output logic [3:0]                 b,
  output logic                       active,
  output logic                       frame_start
);
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HW       = $clog2(H_TOTAL + 1);
  localparam int VW       = $clog2(V_TOTAL + 1);
  localparam int HTW      = $clog2(V_DISPLAY + 1);
  localparam int CW       = $clog2(BAR_WIDTH + 1);
  localparam int BAND_MAX = (H_TOTAL / BAR_WIDTH > NUM_BANDS) ? H_TOTAL / BAR_WIDTH : NUM_BANDS;
  localparam int BNW      = $clog2(BAND_MAX + 2);
  localparam int SW       = $clog2(NUM_BANDS);
  localparam int HOLD_W   = $clog2(PEAK_DECAY_FRAMES + 1);
  localparam int PW       = MAG_W + HTW;
  localparam logic [VW-1:0] VD = VW'(V_DISPLAY);

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [CW-1:0]     col;
  logic [BNW-1:0]    band;
  logic [MAG_W-1:0]  shadow  [NUM_BANDS];
  logic [HTW-1:0]    disp_ht [NUM_BANDS];
  logic [HTW-1:0]    peak    [NUM_BANDS];
  logic [HOLD_W-1:0] hold    [NUM_BANDS];
  logic [HTW-1:0]    new_ht  [NUM_BANDS];
  logic              h_last, v_last, boundary;

  assign h_last   = (h == HW'(H_TOTAL - 1));
  assign v_last   = (v == VW'(V_TOTAL - 1));
  assign boundary = h_last && v_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      h    <= '0;
      v    <= '0;
      col  <= '0;
      band <= '0;
    end else begin
      h <= h_last ? '0 : h + 1'b1;
      if (h_last) v <= v_last ? '0 : v + 1'b1;
      // slot column / band index follow h without a divider
      if (h_last) begin
        col  <= '0;
        band <= '0;
      end else if (col == CW'(BAR_WIDTH - 1)) begin
        col  <= '0;
        band <= band + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_ht
    logic [MAG_W-1:0] mag;
    logic [PW-1:0]    prod, scaled;
    assign mag       = shadow[k];
    assign prod      = mag[MAG_W-1] ? '0 : PW'(mag[MAG_W-2:0]) * PW'(V_DISPLAY);
    assign scaled    = prod >> (MAG_W - 1);
    assign new_ht[k] = (scaled > PW'(V_DISPLAY)) ? HTW'(V_DISPLAY) : scaled[HTW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        shadow[k]  <= '0;
        disp_ht[k] <= '0;
        peak[k]    <= '0;
        hold[k]    <= '0;
      end
    end else begin
      // display reads the pre-strobe shadow when done lands on the boundary
      if (done)
        for (int k = 0; k < NUM_BANDS; k++) shadow[k] <= bands[k*MAG_W +: MAG_W];
      if (boundary) begin
        for (int k = 0; k < NUM_BANDS; k++) begin
          disp_ht[k] <= new_ht[k];
          if (new_ht[k] >= peak[k]) begin
            peak[k] <= new_ht[k];
            hold[k] <= '0;
          end else if (hold[k] == HOLD_W'(PEAK_DECAY_FRAMES - 1)) begin
            hold[k] <= '0;
            peak[k] <= ((peak[k] - 1'b1) > new_ht[k]) ? peak[k] - 1'b1 : new_ht[k];
          end else begin
            hold[k] <= hold[k] + 1'b1;
          end
        end
      end
    end
  end

  logic          in_bars;
  logic [SW-1:0] sel;
  logic [HTW-1:0] cur_ht, cur_peak;
  logic [11:0]   color;

  assign in_bars  = (band < BNW'(NUM_BANDS));
  assign sel      = in_bars ? band[SW-1:0] : '0;
  assign cur_ht   = disp_ht[sel];
  assign cur_peak = peak[sel];

  always_comb begin
    color = 12'h000;
    if (h < HW'(H_DISPLAY) && v < VD && in_bars && col < CW'(BAR_WIDTH - GAP)) begin
      if (cur_peak != '0 && v == VD - VW'(cur_peak))
        color = 12'hFFF;
      else if (v >= VD - VW'(cur_ht)) begin
        if (v < VW'(V_DISPLAY / 3))          color = 12'hC00;
        else if (v < VW'(2 * V_DISPLAY / 3)) color = 12'hCC0;
        else                                 color = 12'h0C0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      frame_start <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      hsync       <= !(h >= HW'(H_DISPLAY + H_FRONT) && h < HW'(H_DISPLAY + H_FRONT + H_SYNC));
      vsync       <= !(v >= VW'(V_DISPLAY + V_FRONT) && v < VW'(V_DISPLAY + V_FRONT + V_SYNC));
      active      <= (h < HW'(H_DISPLAY)) && (v < VD);
      frame_start <= (h == '0) && (v == '0);
      r           <= color[11:8];
      g           <= color[7:4];
      b           <= color[3:0];
    end
  end
endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Bench for spectrum_bar_renderer on a shrunken raster (80x55) so many frames fit;
// a frame-level model predicts every output cycle, literal pixels pin the model.
module tb_spectrum_bar_renderer;
  localparam int HD = 64, HF = 4, HS = 8, HB = 4;
  localparam int VD = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB, VT = VD + VF + VS + VB;
  localparam int NB = 3, BW = 16, GAP = 2, MW = 16, PDF = 4;

  logic clk = 1'b0, reset = 1'b1, done = 1'b0;
  logic [NB*MW-1:0] bands = '0;
  logic hsync, vsync, active, frame_start;
  logic [3:0] r, g, b;
  int n_cmp = 0, n_err = 0;

  always #20 clk = ~clk;

  spectrum_bar_renderer #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .NUM_BANDS(NB), .BAR_WIDTH(BW), .GAP(GAP), .MAG_W(MW),
    .PEAK_DECAY_FRAMES(PDF)
  ) dut (
    .clk(clk), .reset(reset), .done(done), .bands(bands),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
    .active(active), .frame_start(frame_start)
  );

  int m_h, m_v, out_x = -1, out_y = -1;
  int m_ht[NB], m_peak[NB], m_hold[NB];
  logic [MW-1:0] m_shadow[NB];
  logic [15:0] exp_vec;
  bit exp_ok = 0;

  function automatic logic [11:0] pix(input int x, input int y);
    int bd, c;
    if (x >= HD || y >= VD) return 12'h000;
    bd = x / BW;
    c  = x % BW;
    if (bd >= NB || c >= BW - GAP) return 12'h000;
    if (m_peak[bd] > 0 && y == VD - m_peak[bd]) return 12'hFFF;
    if (y >= VD - m_ht[bd]) begin
      if (y < VD / 3) return 12'hC00;
      if (y < 2 * VD / 3) return 12'hCC0;
      return 12'h0C0;
    end
    return 12'h000;
  endfunction

  // frame-level model: outputs of cycle t describe the position held at t-1
  initial begin
    int mag, ht;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_h = 0; m_v = 0; out_x = -1; out_y = -1;
        for (int k = 0; k < NB; k++) begin
          m_ht[k] = 0; m_peak[k] = 0; m_hold[k] = 0; m_shadow[k] = '0;
        end
        exp_vec = 16'hC000;
      end else begin
        exp_vec = {!(m_h >= HD + HF && m_h < HD + HF + HS),
                   !(m_v >= VD + VF && m_v < VD + VF + VS),
                   (m_h < HD && m_v < VD), (m_h == 0 && m_v == 0), pix(m_h, m_v)};
        out_x = m_h; out_y = m_v;
        if (m_h == HT - 1 && m_v == VT - 1) begin
          for (int k = 0; k < NB; k++) begin
            mag = $signed(m_shadow[k]);
            if (mag < 0) mag = 0;
            ht = mag * VD / (1 << (MW - 1));
            if (ht > VD) ht = VD;
            m_ht[k] = ht;
            if (ht >= m_peak[k]) begin
              m_peak[k] = ht; m_hold[k] = 0;
            end else if (m_hold[k] == PDF - 1) begin
              m_hold[k] = 0;
              m_peak[k] = (m_peak[k] - 1 > ht) ? m_peak[k] - 1 : ht;
            end else m_hold[k]++;
          end
        end
        if (done)
          for (int k = 0; k < NB; k++) m_shadow[k] = bands[k*MW +: MW];
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else m_h++;
      end
      exp_ok = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (exp_ok) begin
        n_cmp++;
        if ({hsync, vsync, active, frame_start, r, g, b} !== exp_vec) begin
          n_err++;
          $display("FAIL pixel (%0d,%0d): got %h want %h", out_x, out_y,
                   {hsync, vsync, active, frame_start, r, g, b}, exp_vec);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic wait_out(input int x, input int y);
    int i = 0;
    bit hit = 0;
    while (!hit && i < 6000) begin
      @(negedge clk);
      hit = (out_x == x && out_y == y);
      i++;
    end
    if (!hit) begin
      n_cmp++; n_err++;
      $display("FAIL timeout pixel (%0d,%0d)", x, y);
    end
  endtask

  task automatic chk_px(input string name, input int x, input int y, input int expv);
    wait_out(x, y);
    check(name, {r, g, b}, expv);
  endtask

  task automatic send(input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2);
    @(negedge clk);
    bands = {b2, b1, b0};
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic sync_width(input string name, input bit is_v, input int expw);
    int i = 0, w = 0;
    while (i < 6000 && (is_v ? vsync : hsync) !== 1'b0) begin @(negedge clk); i++; end
    while (i < 6000 && (is_v ? vsync : hsync) === 1'b0) begin @(negedge clk); i++; w++; end
    check(name, w, expw);
  endtask

  task automatic fs_period(input int expp);
    int i = 0, p = 0;
    while (i < 6000 && frame_start !== 1'b1) begin @(negedge clk); i++; end
    @(negedge clk);
    p = 1;
    while (p < 6000 && frame_start !== 1'b1) begin @(negedge clk); p++; end
    check("frame period", p, expp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset hsync", hsync, 1);
    reset = 1'b0;
    @(negedge clk);
    check("first frame_start", frame_start, 1);

    // frame 0: band0 half scale, band1 most negative
    send(16'h4000, 16'h8000, 16'h0000);
    sync_width("hsync low width", 1'b0, HS);
    wait_out(0, 0);
    chk_px("b0 above bar", 5, 23, 12'h000);
    chk_px("b0 marker", 5, 24, 12'hFFF);
    chk_px("b0 yellow", 5, 28, 12'hCC0);
    chk_px("b0 gap", 14, 28, 12'h000);
    chk_px("b1 negative", 20, 28, 12'h000);
    chk_px("b0 green", 5, 40, 12'h0C0);
    chk_px("beyond bands", 50, 40, 12'h000);
    check("model ht0", m_ht[0], 24);
    check("model peak1", m_peak[1], 0);

    // full-scale band2, then drop it to watch the peak decay
    send(16'h4000, 16'h8000, 16'h7FFF);
    wait_out(0, 0);
    chk_px("b2 marker row1", 40, 1, 12'hFFF);
    chk_px("b2 red", 40, 2, 12'hC00);
    chk_px("b2 yellow", 40, 20, 12'hCC0);
    check("model peak2", m_peak[2], 47);
    send(16'h4000, 16'h8000, 16'h0000);
    sync_width("vsync low width", 1'b1, VS * HT);
    fs_period(HT * VT);
    chk_px("b2 held marker", 40, 1, 12'hFFF);
    chk_px("b2 bar gone", 40, 10, 12'h000);
    wait_out(0, 0);
    wait_out(0, 0);
    chk_px("b2 decayed old row", 40, 1, 12'h000);
    chk_px("b2 decayed marker", 40, 2, 12'hFFF);

    // done coincident with the frame boundary
    wait_out(HT - 2, VT - 1);
    bands = {16'h0000, 16'h8000, 16'h2000};
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk_px("boundary old data", 5, 30, 12'hCC0);
    chk_px("new data peak held", 5, 24, 12'hFFF);
    chk_px("new data row30", 5, 30, 12'h000);
    chk_px("new data green", 5, 40, 12'h0C0);
    check("model ht0 new", m_ht[0], 12);

    // mid-line reset
    wait_out(30, 10);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("frame_start after reset", frame_start, 1);
    chk_px("cleared after reset", 5, 40, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
